serial_substractor: RTL and testbench
=====================================

SERIAL_SUBSTRACTOR -- requirements
Module: serial_substractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-005 SHALL have port a  input  WIDTH  minuend; captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse; diff and b_out are valid.
REQ-009 SHALL have port diff  output  WIDTH  result a-b.
REQ-010 SHALL have port b_out  output  1  final borrow; 1 when a<b unsigned.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
- Transitions: IDLE->RUN on start; RUN->DONE after WIDTH bit-cycles; DONE->IDLE unconditionally.
REQ-012 SHALL accept start only in IDLE.
- On acceptance: capture a and b into shift registers, clear the borrow flop to 0, clear the bit counter to 0.
REQ-013 SHALL process one bit per clk in RUN, LSB first.
- d = a_i ^ b_i ^ borrow.
- next borrow = (~a_i & b_i) | (~(a_i ^ b_i) & borrow).
- d shifts into the result register from the MSB side.
REQ-014 SHALL count bit-cycles with a counter of $clog2(WIDTH+1) bits that wraps to 0 on acceptance of start, never beyond WIDTH-1.
REQ-015 SHALL make latency fixed: start sampled at edge E0 -> done high for exactly one cycle after edge E(WIDTH).
REQ-016 SHALL assert busy in RUN only and done in DONE only; busy and done SHALL never be high together.
REQ-017 SHALL update diff and b_out only on entry to DONE and hold them until the next entry to DONE.
REQ-018 SHALL ignore start while in RUN or DONE; no re-capture and no effect on the in-flight result.
REQ-019 SHALL ignore changes on a and b except at the start-accept edge.
REQ-020 SHALL produce a modulo-2^WIDTH result, with b_out equal to the borrow out of bit WIDTH-1.

Reset
REQ-021 SHALL, on rst_n low and regardless of clk, force:
- state=IDLE, busy=0, done=0, diff=0, b_out=0;
- shift registers, borrow flop and counter to 0.
REQ-022 SHALL, on reset asserted mid-RUN, abort the operation with no done pulse; after release, the block SHALL wait in IDLE for a new start.

Configuration
REQ-023 SHALL support macro SERIAL_SUB_SATURATE_EN.
- Defined: when the final borrow is 1, diff SHALL be 0 (saturate at zero) and b_out SHALL still be 1.
- Undefined: diff SHALL be the wrapped two's-complement result.
- Latency and handshake SHALL be identical in both builds.

Structure
REQ-024 SHALL place FSM state encoding (2-bit typedef: IDLE, RUN, DONE) and the default WIDTH constant in a shared package serial_sub_pkg.
REQ-025 SHALL instantiate the existing 1-bit full_substractor as its only sub-module for the per-bit difference/borrow of REQ-013.

Verification (WIDTH=8)
REQ-026 SHALL cover a=0x5A, b=0x23, start for 1 cycle -> busy for 8 cycles, then done pulse, diff=0x37, b_out=0.
REQ-027 SHALL cover a=0x00, b=0x01 -> diff=0xFF, b_out=1; with SERIAL_SUB_SATURATE_EN: diff=0x00, b_out=1.
REQ-028 SHALL cover a=0xFF, b=0xFF, then a=0x80, b=0x7F issued back-to-back from IDLE -> diff=0x00, b_out=0, then diff=0x01, b_out=0; diff holds between done pulses.
REQ-029 SHALL cover start re-pulsed with a=0x11, b=0x22 during RUN of 0x5A-0x23 -> ignored; result stays 0x37 at the original latency.
REQ-030 SHALL cover rst_n low at bit-cycle 4 of 0xF0-0x0F -> outputs 0 immediately, no done; new start after release gives 0xE1, b_out=0.

Source files
------------

// File: rtl/serial_substractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   sub_state_t       : 2-bit FSM state encoding (IDLE, RUN, DONE)
//   SUB_WIDTH_DEFAULT : default operand/result width in bits
package serial_sub_pkg;

  localparam int unsigned SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_substractor_full_substractor.sv
// 1-bit full subtractor: d = a - b - bin, with borrow out.
// Ports:
//   i_a, i_b : operand bits
//   i_bin    : borrow in
//   o_d      : difference bit
//   o_bout   : borrow out
module full_substractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_substractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// A start accepted in IDLE captures a/b; WIDTH cycles later done pulses for
// one cycle with diff/b_out updated. diff/b_out hold until the next done.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a subtraction (accepted only when idle)
//   a, b       : minuend, subtrahend (captured at the start-accept edge)
//   busy       : high while bits are being processed
//   done       : single-cycle pulse, diff/b_out valid
//   diff       : result a-b (mod 2^WIDTH)
//   b_out      : final borrow, 1 when a < b
// Build option: SERIAL_SUB_SATURATE_EN -- when defined, diff saturates to 0
// whenever the final borrow is 1 (b_out still reports 1).
module serial_substractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_t       r_state;
  sub_state_t       w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_b_out;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_diff_final;

  full_substractor u_fs (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_bin (r_borrow),
    .o_d   (w_d),
    .o_bout(w_bout)
  );

  assign w_last     = (r_cnt == LAST_BIT);
  // Result fills from the MSB side so the last bit lands in bit WIDTH-1.
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

`ifdef SERIAL_SUB_SATURATE_EN
  assign w_diff_final = w_bout ? '0 : w_res_next;
`else
  assign w_diff_final = w_res_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_next = RUN;
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_b_out  <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_bout;
          r_res    <= w_res_next;
          if (w_last) begin
            r_cnt   <= '0;
            r_diff  <= w_diff_final;
            r_b_out <= w_bout;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = w_busy;
  assign done  = w_done;
  assign diff  = r_diff;
  assign b_out = r_b_out;

endmodule

// File: tb/tb_serial_substractor.sv
module tb_serial_substractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [W-1:0] prev_diff;
  logic         prev_bout;

  serial_substractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .diff (diff),
    .b_out(b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: unsigned subtraction with one extra bit to expose the borrow.
  task automatic ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                         output logic [W-1:0] rd, output logic rbo);
    logic [W:0] full;
    full = {1'b0, ra} - {1'b0, rb};
    rbo  = full[W];
    rd   = full[W-1:0];
`ifdef SERIAL_SUB_SATURATE_EN
    if (rbo) rd = '0;
`endif
  endtask

  // One subtraction with full handshake/latency checking.
  // inj:       re-pulse start with different operands during RUN.
  // hold_done: keep start high through the DONE cycle (must be ignored).
  task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                       input bit inj, input bit hold_done);
    logic [W-1:0] exp_d;
    logic         exp_b;
    ref_sub(op_a, op_b, exp_d, exp_b);
    @(negedge clk);
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      check("busy_run", {31'd0, busy}, 32'd1);
      check("done_run", {31'd0, done}, 32'd0);
      check("diff_hold", {24'd0, diff}, {24'd0, prev_diff});
      check("bout_hold", {31'd0, b_out}, {31'd0, prev_bout});
      a = W'($urandom);
      b = W'($urandom);
      if (inj && k == 2) begin
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("diff", {24'd0, diff}, {24'd0, exp_d});
    check("b_out", {31'd0, b_out}, {31'd0, exp_b});
    prev_diff = exp_d;
    prev_bout = exp_b;
    start = hold_done;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_single", {31'd0, done}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("diff_after", {24'd0, diff}, {24'd0, prev_diff});
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    prev_diff = '0;
    prev_bout = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, b_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    do_op(8'h5A, 8'h23, 1'b0, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    do_op(8'h80, 8'h7F, 1'b0, 1'b0);
    do_op(8'h5A, 8'h23, 1'b1, 1'b1);

    // Reset during bit-cycle 4 of 0xF0 - 0x0F
    @(negedge clk);
    start = 1'b1;
    a     = 8'hF0;
    b     = 8'h0F;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_diff", {24'd0, diff}, 32'd0);
    check("midrst_bout", {31'd0, b_out}, 32'd0);
    prev_diff = '0;
    prev_bout = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("postrst_idle_done", {31'd0, done}, 32'd0);
      check("postrst_idle_busy", {31'd0, busy}, 32'd0);
    end
    do_op(8'hF0, 8'h0F, 1'b0, 1'b0);

    // Randomized operations with random gaps, re-pulses and operand churn
    for (int n = 0; n < 60; n++) begin
      int unsigned gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < int'(gap); g++) begin
        @(posedge clk);
        #1;
        check("gap_busy", {31'd0, busy}, 32'd0);
      end
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
